// File: rtl/ft2_pkg.sv
// Shared types and helpers for the FT2232H async-FIFO engines.
// Holds the read-strobe FSM encoding and the byte-lane mapping used by the assembler.
package ft2_pkg;

    localparam int unsigned FT2_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RECOVER = 2'd2
    } ft2_state_e;

    // Lane that the idx-th received byte of a word occupies.
    function automatic int unsigned ft2_lane(input int unsigned idx,
                                             input int unsigned bpw,
                                             input bit          msb_first);
        return msb_first ? (bpw - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/ft2_sync2.sv
// Two-flop synchroniser for FT2232H status pins (RXF#, TXE#).
// Resets to 1 so an idle, active-low flag reads as deasserted.
module ft2_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ft2_rx_assembler.sv
// FT2232H async-FIFO read engine: strobes RD#, packs bytes into words, streams them out.
// Optional macro FT2_RX_TIMEOUT_EN flushes a stale partial word after TIMEOUT_CYC idle cycles.
module ft2_rx_assembler
    import ft2_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned RD_LOW_CYC     = 3,
    parameter int unsigned RD_HIGH_CYC    = 2,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYC    = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   rxf_n_in,
    input  logic [FT2_BYTE_W-1:0]                  d_in,
    output logic                                   rd_n_out,
    output logic                                   wr_n_out,
    input  logic                                   flush_in,
    output logic [FT2_BYTE_W*BYTES_PER_WORD-1:0]   m_data,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic                                   m_partial,
    output logic [$clog2(BYTES_PER_WORD):0]        byte_idx
);

    localparam int unsigned IDX_W   = $clog2(BYTES_PER_WORD) + 1;
    localparam int unsigned WORD_W  = FT2_BYTE_W * BYTES_PER_WORD;
    localparam int unsigned CYC_MAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
    localparam int unsigned CNT_W   = $clog2(CYC_MAX);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(RD_HIGH_CYC - 1);

    if (BYTES_PER_WORD < 1 || BYTES_PER_WORD > 8) begin : g_bad_bpw
        $error("ft2_rx_assembler: BYTES_PER_WORD must be 1..8");
    end
    if (RD_LOW_CYC < 2 || RD_HIGH_CYC < 1) begin : g_bad_timing
        $error("ft2_rx_assembler: RD_LOW_CYC must be >= 2 and RD_HIGH_CYC >= 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("ft2_rx_assembler: TIMEOUT_CYC must be >= 1");
    end

    ft2_state_e         r_state;
    ft2_state_e         w_state_next;
    logic [CNT_W-1:0]   r_cyc_cnt;
    logic               r_rd_n;
    logic [WORD_W-1:0]  r_partial_word;
    logic [IDX_W-1:0]   r_byte_idx;
    logic [WORD_W-1:0]  r_m_data;
    logic               r_m_valid;
    logic               r_flush_pend;

    logic               w_rxf_s;
    logic               w_out_free;
    logic               w_space;
    logic               w_capture;
    logic               w_last_byte;
    logic               w_discard;
    logic               w_to_fire;
    int unsigned        w_lane;
    logic [WORD_W-1:0]  w_word;

    ft2_sync2 u_rxf_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxf_n_in),
        .o_q (w_rxf_s)
    );

    assign w_out_free  = !r_m_valid || m_ready;
    // Only the word-completing byte needs the output register; earlier bytes may be read while stalled.
    assign w_space     = (r_byte_idx < LAST_IDX) || w_out_free;
    assign w_last_byte = (r_byte_idx == LAST_IDX);
    assign w_discard   = r_flush_pend || flush_in;
    assign w_lane      = ft2_lane(32'(r_byte_idx), BYTES_PER_WORD, MSB_FIRST);

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        assign w_word[gi*FT2_BYTE_W +: FT2_BYTE_W] =
            (w_lane == unsigned'(gi)) ? d_in : r_partial_word[gi*FT2_BYTE_W +: FT2_BYTE_W];
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxf_s && w_space) w_state_next = STROBE;
            end
            STROBE: begin
                if (r_cyc_cnt == LOW_LAST) begin
                    w_state_next = RECOVER;
                    w_capture    = 1'b1;
                end
            end
            RECOVER: begin
                if (r_cyc_cnt == HIGH_LAST) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cyc_cnt <= '0;
            r_rd_n    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_rd_n    <= (w_state_next != STROBE);
            r_cyc_cnt <= (w_state_next != r_state || r_state == IDLE) ? '0 : r_cyc_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_partial_word <= '0;
            r_byte_idx     <= '0;
            r_m_data       <= '0;
            r_m_valid      <= 1'b0;
            r_flush_pend   <= 1'b0;
        end else begin
            if (r_m_valid && m_ready) r_m_valid <= 1'b0;
            if (flush_in) begin
                r_partial_word <= '0;
                r_byte_idx     <= '0;
            end
            if (w_capture) begin
                r_flush_pend <= 1'b0;
                if (w_discard) begin
                    r_partial_word <= '0;
                    r_byte_idx     <= '0;
                end else if (w_last_byte) begin
                    r_m_data       <= w_word;
                    r_m_valid      <= 1'b1;
                    r_partial_word <= '0;
                    r_byte_idx     <= '0;
                end else begin
                    r_partial_word <= w_word;
                    r_byte_idx     <= r_byte_idx + IDX_W'(1);
                end
            end else if (flush_in && r_state == STROBE) begin
                // The strobe in flight still finishes, but its byte belongs to the flushed word.
                r_flush_pend <= 1'b1;
            end else if (w_to_fire) begin
                r_m_data       <= r_partial_word;
                r_m_valid      <= 1'b1;
                r_partial_word <= '0;
                r_byte_idx     <= '0;
            end
        end
    end

`ifdef FT2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_m_partial;
    logic            w_to_run;

    assign w_to_run  = (r_state == IDLE) && (r_byte_idx != '0) && w_rxf_s && !flush_in;
    assign w_to_fire = w_to_run && (r_to_cnt == TO_LAST) && w_out_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt    <= '0;
            r_m_partial <= 1'b0;
        end else begin
            if (!w_to_run)             r_to_cnt <= '0;
            else if (r_to_cnt != TO_LAST) r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_to_fire)                                    r_m_partial <= 1'b1;
            else if (w_capture && w_last_byte && !w_discard) r_m_partial <= 1'b0;
        end
    end

    assign m_partial = r_m_partial;
`else
    assign w_to_fire = 1'b0;
    assign m_partial = 1'b0;
`endif

    assign rd_n_out = r_rd_n;
    assign wr_n_out = 1'b1;
    assign m_data   = r_m_data;
    assign m_valid  = r_m_valid;
    assign byte_idx = r_byte_idx;

endmodule

// File: tb/tb_ft2_rx_assembler.sv
// Self-checking bench for ft2_rx_assembler with a behavioural FT2232H FIFO and word scoreboard.
// Runs the timeout scenario when FT2_RX_TIMEOUT_EN is defined, the wait-forever scenario otherwise.
module tb_ft2_rx_assembler;

    localparam int BPW  = 4;
    localparam int LOW  = 3;
    localparam int HIGH = 2;
    localparam int TO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        rxf_n_in = 1'b1;
    logic [7:0]  d_in = 8'h00;
    logic        rd_n_out, wr_n_out;
    logic        flush_in = 1'b0;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_partial;
    logic [2:0]  byte_idx;

    logic        b_rxf_n = 1'b1;
    logic [7:0]  b_d = 8'h00;
    logic        b_rd_n, b_wr_n;
    logic [31:0] b_m_data;
    logic        b_m_valid;
    logic        b_m_ready = 1'b0;
    logic        b_m_partial;
    logic [2:0]  b_byte_idx;

    ft2_rx_assembler #(
        .BYTES_PER_WORD(BPW), .RD_LOW_CYC(LOW), .RD_HIGH_CYC(HIGH),
        .MSB_FIRST(1'b1), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .rxf_n_in(rxf_n_in), .d_in(d_in),
        .rd_n_out(rd_n_out), .wr_n_out(wr_n_out), .flush_in(flush_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_partial(m_partial), .byte_idx(byte_idx)
    );

    ft2_rx_assembler #(
        .BYTES_PER_WORD(BPW), .RD_LOW_CYC(LOW), .RD_HIGH_CYC(HIGH),
        .MSB_FIRST(1'b0), .TIMEOUT_CYC(TO)
    ) dut_lsb (
        .clk(clk), .rst(rst), .rxf_n_in(b_rxf_n), .d_in(b_d),
        .rd_n_out(b_rd_n), .wr_n_out(b_wr_n), .flush_in(1'b0),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_partial(b_m_partial), .byte_idx(b_byte_idx)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // FT2232H model: bytes wait in ft_q; RXF# low while data is buffered; rising RD# consumes one.
    byte unsigned ft_q[$];
    logic         rxf_force   = 1'b0;
    logic         rd_prev     = 1'b1;
    int           low_len     = 0;
    bit           pulse_abort = 1'b0;
    int           strobe_cnt  = 0;

    always @(negedge clk) begin
        if (!rd_n_out) low_len++;
        if (!rd_n_out && rd_prev) strobe_cnt++;
        if (rd_n_out && !rd_prev) begin
            if (!pulse_abort) begin
                n_cmp++;
                if (low_len != LOW) begin
                    n_fail++;
                    $display("FAIL rd_low_width: got %0d cycles, want %0d", low_len, LOW);
                end
            end
            if (ft_q.size() > 0) void'(ft_q.pop_front());
            low_len     = 0;
            pulse_abort = 1'b0;
        end
        rd_prev  = rd_n_out;
        rxf_n_in = (ft_q.size() == 0) || rxf_force;
        d_in     = (ft_q.size() > 0) ? ft_q[0] : 8'h00;
    end

    logic [7:0] b_bytes [4];
    int         b_n = 0;
    int         b_idx = 0;
    logic       b_rd_prev = 1'b1;

    always @(negedge clk) begin
        if (b_rd_n && !b_rd_prev) b_idx++;
        b_rd_prev = b_rd_n;
        b_rxf_n   = (b_idx >= b_n);
        b_d       = (b_idx < b_n && b_idx < 4) ? b_bytes[b_idx] : 8'h00;
    end

    // Scoreboard: every accepted word must match the next expected {partial, data}.
    logic [32:0] exp_q[$];
    int          words_seen = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%b data=%h, want valid=1 data=%h", m_valid, m_data, prev_data);
                end
            end
            if (m_valid && m_ready) begin
                logic [32:0] e;
                n_cmp++;
                words_seen++;
                $display("word #%0d data=0x%08h partial=%0b", words_seen, m_data, m_partial);
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, none expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_partial, m_data} !== e) begin
                        n_fail++;
                        $display("FAIL word_data: got partial=%b data=%h, want partial=%b data=%h",
                                 m_partial, m_data, e[32], e[31:0]);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    function automatic logic [31:0] ref_word(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input bit msb_first);
        logic [7:0]  b [4];
        logic [31:0] w;
        b = '{b0, b1, b2, b3};
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (msb_first) w = (w << 8) | 32'(b[i]);
            else           w = w | (32'(b[i]) << (8 * i));
        end
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick(1);
            i++;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        ft_q.push_back(b0); ft_q.push_back(b1); ft_q.push_back(b2); ft_q.push_back(b3);
        exp_q.push_back({1'b0, ref_word(b0, b1, b2, b3, 1'b1)});
    endtask

    task automatic test_reset;
        tick(3);
        n_cmp += 6;
        if (rd_n_out !== 1'b1)  begin n_fail++; $display("FAIL reset_rd_n: got %b want 1", rd_n_out); end
        if (wr_n_out !== 1'b1)  begin n_fail++; $display("FAIL reset_wr_n: got %b want 1", wr_n_out); end
        if (m_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        if (m_data !== 32'h0)   begin n_fail++; $display("FAIL reset_data: got %h want 0", m_data); end
        if (m_partial !== 1'b0) begin n_fail++; $display("FAIL reset_partial: got %b want 0", m_partial); end
        if (byte_idx !== 3'd0)  begin n_fail++; $display("FAIL reset_byte_idx: got %0d want 0", byte_idx); end
        rst = 1'b0;
        tick(5);
        n_cmp += 2;
        if (rd_n_out !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: rd_n=%b valid=%b want 1/0", rd_n_out, m_valid);
        end
        if (b_rd_n !== 1'b1 || b_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle_lsb: rd_n=%b valid=%b want 1/0", b_rd_n, b_m_valid);
        end
    endtask

    task automatic test_basic;
        bit ok;
        int w0;
        m_ready = 1'b1;
        w0 = words_seen;
        push_word(8'h11, 8'h22, 8'h33, 8'h44);
        wait_drain(300, ok);
        tick(20);
        n_cmp += 3;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: %0d words pending, want 0", exp_q.size()); end
        if (words_seen - w0 != 1) begin
            n_fail++; $display("FAIL basic_word_count: got %0d want 1", words_seen - w0);
        end
        if (byte_idx !== 3'd0) begin n_fail++; $display("FAIL basic_byte_idx: got %0d want 0", byte_idx); end
    endtask

    task automatic test_lsb_first;
        int i;
        logic [31:0] want;
        b_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        b_n = 4;
        want = ref_word(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        i = 0;
        while (b_m_valid !== 1'b1 && i < 300) begin tick(1); i++; end
        n_cmp += 3;
        if (b_m_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_valid_timeout: got %b want 1", b_m_valid); end
        if (b_m_data !== want) begin n_fail++; $display("FAIL lsb_data: got %h want %h", b_m_data, want); end
        if (b_m_partial !== 1'b0 || b_byte_idx !== 3'd0) begin
            n_fail++; $display("FAIL lsb_status: partial=%b idx=%0d want 0/0", b_m_partial, b_byte_idx);
        end
        b_m_ready = 1'b1;
        tick(1);
        b_m_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [7:0]  b [12];
        logic [31:0] w1;
        int          s0, i;
        bit          ok;
        for (int k = 0; k < 12; k++) b[k] = 8'($urandom_range(0, 255));
        w1 = ref_word(b[0], b[1], b[2], b[3], 1'b1);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_word(b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]);
        i = 0;
        while (m_valid !== 1'b1 && i < 300) begin tick(1); i++; end
        s0 = strobe_cnt;
        tick(200);
        n_cmp += 5;
        if (strobe_cnt - s0 != 3) begin
            n_fail++; $display("FAIL bp_strobes: got %0d want 3", strobe_cnt - s0);
        end
        if (ft_q.size() != 5) begin n_fail++; $display("FAIL bp_fifo_left: got %0d want 5", ft_q.size()); end
        if (rd_n_out !== 1'b1) begin n_fail++; $display("FAIL bp_rd_high: got %b want 1", rd_n_out); end
        if (m_valid !== 1'b1 || m_data !== w1) begin
            n_fail++; $display("FAIL bp_first_word: valid=%b data=%h want 1/%h", m_valid, m_data, w1);
        end
        if (byte_idx !== 3'd3) begin n_fail++; $display("FAIL bp_byte_idx: got %0d want 3", byte_idx); end
        m_ready = 1'b1;
        wait_drain(400, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL bp_drain: %0d words pending, want 0", exp_q.size()); end
    endtask

    task automatic test_flush_idle;
        int i;
        bit ok;
        m_ready = 1'b1;
        ft_q.push_back(8'hAA);
        ft_q.push_back(8'hBB);
        i = 0;
        while (byte_idx !== 3'd2 && i < 200) begin tick(1); i++; end
        tick(10);
        n_cmp += 2;
        if (byte_idx !== 3'd2) begin n_fail++; $display("FAIL flush_pre_idx: got %0d want 2", byte_idx); end
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 0", m_valid); end
        flush_in = 1'b1;
        tick(1);
        flush_in = 1'b0;
        n_cmp++;
        if (byte_idx !== 3'd0) begin n_fail++; $display("FAIL flush_idx: got %0d want 0", byte_idx); end
        ft_q.push_back(8'h01); ft_q.push_back(8'h02); ft_q.push_back(8'h03); ft_q.push_back(8'h04);
        exp_q.push_back({1'b0, 32'h01020304});
        wait_drain(300, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL flush_word_timeout: %0d pending, want 0", exp_q.size()); end
    endtask

    task automatic test_flush_mid_strobe;
        int i;
        bit ok;
        ft_q.push_back(8'hC3);
        i = 0;
        while (rd_n_out !== 1'b0 && i < 100) begin tick(1); i++; end
        n_cmp++;
        if (rd_n_out !== 1'b0) begin n_fail++; $display("FAIL fms_no_strobe: rd_n=%b want 0", rd_n_out); end
        flush_in = 1'b1;
        tick(1);
        flush_in = 1'b0;
        tick(LOW + HIGH + 4);
        n_cmp++;
        if (byte_idx !== 3'd0) begin n_fail++; $display("FAIL fms_byte_idx: got %0d want 0", byte_idx); end
        push_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        wait_drain(300, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL fms_word_timeout: %0d pending, want 0", exp_q.size()); end
    endtask

    task automatic test_timeout;
        int i, k;
        m_ready = 1'b1;
        ft_q.push_back(8'h5A);
        i = 0;
        while (byte_idx !== 3'd1 && i < 100) begin tick(1); i++; end
        n_cmp++;
        if (byte_idx !== 3'd1) begin n_fail++; $display("FAIL to_capture: idx=%0d want 1", byte_idx); end
`ifdef FT2_RX_TIMEOUT_EN
        exp_q.push_back({1'b1, 32'h5A000000});
        k = 0;
        while (m_valid !== 1'b1 && k < 200) begin tick(1); k++; end
        n_cmp += 3;
        if (m_valid !== 1'b1) begin n_fail++; $display("FAIL to_no_flush: valid=%b want 1", m_valid); end
        if (m_data !== 32'h5A000000 || m_partial !== 1'b1) begin
            n_fail++; $display("FAIL to_word: data=%h partial=%b want 5a000000/1", m_data, m_partial);
        end
        // RD# rises at the capture edge, RECOVER lasts HIGH cycles, then TO idle cycles elapse.
        if (k != HIGH + TO) begin n_fail++; $display("FAIL to_latency: got %0d cycles want %0d", k, HIGH + TO); end
        tick(2);
        n_cmp++;
        if (byte_idx !== 3'd0) begin n_fail++; $display("FAIL to_byte_idx: got %0d want 0", byte_idx); end
`else
        k = 0;
        tick(TO * 6);
        n_cmp += 2;
        if (m_valid !== 1'b0 || m_partial !== 1'b0) begin
            n_fail++; $display("FAIL nto_flushed: valid=%b partial=%b want 0/0", m_valid, m_partial);
        end
        if (byte_idx !== 3'd1) begin n_fail++; $display("FAIL nto_idx: got %0d want 1 (k=%0d)", byte_idx, k); end
        flush_in = 1'b1;
        tick(1);
        flush_in = 1'b0;
        n_cmp++;
        if (byte_idx !== 3'd0) begin n_fail++; $display("FAIL nto_flush_idx: got %0d want 0", byte_idx); end
`endif
    endtask

    task automatic test_random;
        int i;
        for (int w = 0; w < 12; w++)
            push_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        i = 0;
        while (exp_q.size() != 0 && i < 5000) begin
            m_ready   = ($urandom_range(0, 2) != 0);
            rxf_force = ($urandom_range(0, 7) == 0);
            tick(1);
            i++;
        end
        m_ready   = 1'b1;
        rxf_force = 1'b0;
        tick(10);
        n_cmp += 3;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_pending: %0d words want 0", exp_q.size()); end
        if (ft_q.size() != 0) begin n_fail++; $display("FAIL rand_fifo_left: %0d bytes want 0", ft_q.size()); end
        if (byte_idx !== 3'd0) begin n_fail++; $display("FAIL rand_byte_idx: got %0d want 0", byte_idx); end
    endtask

    task automatic test_reset_mid_strobe;
        int i;
        bit ok;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) ft_q.push_back(8'($urandom_range(0, 255)));
        i = 0;
        while (rd_n_out !== 1'b0 && i < 100) begin tick(1); i++; end
        tick(1);
        #2;
        pulse_abort = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (rd_n_out !== 1'b1) begin n_fail++; $display("FAIL rms_rd_n: got %b want 1", rd_n_out); end
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rms_valid: got %b want 0", m_valid); end
        if (byte_idx !== 3'd0) begin n_fail++; $display("FAIL rms_byte_idx: got %0d want 0", byte_idx); end
        tick(2);
        ft_q.delete();
        exp_q.delete();
        rst = 1'b0;
        tick(3);
        push_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        wait_drain(300, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL rms_word_timeout: %0d pending, want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_lsb_first;
        test_backpressure;
        test_flush_idle;
        test_flush_mid_strobe;
        test_timeout;
        test_random;
        test_reset_mid_strobe;
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ft2_rx_assembler.md
Name: ft2_rx_assembler

Overview:
- Parametrised FT2232H async-FIFO read engine; successor to the fixed 4-byte reader.
- Strobes RD# against RXF# with configurable strobe and recovery timing.
- Assembles BYTES_PER_WORD bytes, in a selectable byte order, into one word.
- Presents each word on a valid/ready stream with backpressure. Sits between the FT2232H pins and the command/capture logic.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; legal range 1..8.
- RD_LOW_CYC, 3, clk cycles RD# is held low; data is sampled on the last low cycle; minimum 2.
- RD_HIGH_CYC, 2, clk cycles RD# is held high before the next strobe may start; minimum 1.
- MSB_FIRST, 1, 1 means the first byte lands in the top byte lane; 0 means it lands in lane 0.
- TIMEOUT_CYC, 1024, idle cycles before a partial word is flushed (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rxf_n_in  in  1  FT2232H RXF#, asynchronous to clk
- d_in  in  8  FT2232H data bus
- rd_n_out  out  1  FT2232H RD#
- wr_n_out  out  1  FT2232H WR#, constant 1
- flush_in  in  1  discard the partial word; single-cycle pulse
- m_data  out  8*BYTES_PER_WORD  assembled word
- m_valid  out  1  m_data is valid
- m_ready  in  1  consumer accepts m_data
- m_partial  out  1  the word in m_data is timeout-flushed (0 when the optional feature is off)
- byte_idx  out  $clog2(BYTES_PER_WORD)+1  count of bytes held in the partial word

Behaviour:
- Reset values: rd_n_out=1, m_valid=0, m_data=0, m_partial=0, byte_idx=0, FSM=IDLE. Synchroniser flops reset to 1.
- Synchronisation: rxf_n_in passes through a 2-flop synchroniser to give rxf_s. Only rxf_s is used.
- IDLE: go to STROBE when rxf_s==0 AND space is available.
  - Space is available when byte_idx<BYTES_PER_WORD-1, OR m_valid==0, OR m_ready==1.
  - On entry to STROBE, rd_n_out goes low (registered output, low from the next edge).
- STROBE: hold rd_n_out=0 for exactly RD_LOW_CYC cycles.
  - On the last cycle, capture d_in into lane byte_idx (MSB_FIRST selects lane order) and increment byte_idx.
  - Then go to RECOVER with rd_n_out=1.
- RECOVER: hold rd_n_out=1 for RD_HIGH_CYC cycles, then go to IDLE.
  - RXF# is ignored during RECOVER, because the FT2232H deasserts it after each byte.
- Word completion: when the captured byte fills the word, transfer the word to the output register in the same cycle.
  - Set m_valid=1, m_partial=0, byte_idx=0.
  - The space rule guarantees the output register is free or being drained that cycle.
- Output handshake: m_data and m_valid stay stable while m_valid && !m_ready.
  - The transfer occurs on m_valid && m_ready.
  - A new word may load in the same cycle as the transfer (back-to-back, no bubble).
- Backpressure: the last byte of a word is never strobed while the output register is stalled. RD# stays high and the FT2232H buffers the data.
- Byte lanes: unused bits of a partial word are 0.
- flush_in:
  - Clears the partial word and byte_idx at the next edge.
  - If it arrives during STROBE, the strobe completes, but the captured byte is discarded and byte_idx ends at 0.
  - The output register is unaffected.
- Reset mid-strobe: rd_n_out returns high immediately (asynchronous), and the partial word is lost.
- Throughput: one byte per RD_LOW_CYC+RD_HIGH_CYC+1 cycles at most.

Optional Feature:
- Macro: FT2_RX_TIMEOUT_EN.
- With the macro: a counter runs while FSM=IDLE, byte_idx>0 and rxf_s==1.
  - It resets on any strobe or flush.
  - At TIMEOUT_CYC it loads the partial word into the output register (when free) with m_partial=1 and byte_idx=0.
  - If the output register is stalled, the flush waits and the counter saturates.
- Without the macro: no counter logic, m_partial is tied 0, and partial words wait indefinitely.

Decomposition:
- Package ft2_pkg holds:
  - The FSM state enum (IDLE, STROBE, RECOVER).
  - FT2_BYTE_W=8.
  - A function that maps byte_idx to a lane offset given MSB_FIRST.
- Sub-module ft2_sync2: a 2-flop synchroniser with asynchronous reset value of 1, reused later for TXE#.

Test Plan:
- Default params, RXF# low, bytes 0x11,0x22,0x33,0x44, m_ready=1 -> one m_valid pulse with m_data=0x11223344; each RD# low pulse is exactly 3 clk.
- MSB_FIRST=0, same bytes -> m_data=0x44332211.
- m_ready=0 after the first word, then 8 more bytes offered -> exactly 3 further strobes, RD# held high, first word stable. Set m_ready=1 -> words 2 and 3 follow with no loss.
- flush_in pulsed after 2 bytes (0xAA,0xBB), then 0x01..0x04 -> m_data=0x01020304, and byte_idx returns to 0 after the flush.
- FT2_RX_TIMEOUT_EN, TIMEOUT_CYC=16, a single byte 0x5A, then RXF# high -> m_data=0x5A000000 with m_partial=1, 16 cycles after idle begins.
- rst asserted mid-STROBE -> rd_n_out=1 within the same cycle, m_valid=0; the next 4 bytes assemble correctly.
